// File: rtl/wireframe_fb_ctrl_if.sv
// Bundle of rasteriser write, parity check, scan-out read and status
// signals between the framebuffer controller and its neighbours.
interface wireframe_fb_ctrl_if #(
    parameter int X_W = 7,
    parameter int Y_W = 6
);
    logic           clear_req;
    logic           wr_valid;
    logic           wr_ready;
    logic [X_W-1:0] wr_x;
    logic [Y_W-1:0] wr_y;
    logic           wr_data;
    logic           wr_nopar;
    logic           chk_req;
    logic [Y_W-1:0] chk_y;
    logic           chk_done;
    logic           chk_ok;
    logic           rd_valid;
    logic [X_W-1:0] rd_x;
    logic [Y_W-1:0] rd_y;
    logic           rd_data_valid;
    logic           rd_data;
    logic           busy;
    logic           oob_err;
    logic           err_clr;

    modport master (
        output clear_req, wr_valid, wr_x, wr_y, wr_data, wr_nopar,
               chk_req, chk_y, rd_valid, rd_x, rd_y, err_clr,
        input  wr_ready, chk_done, chk_ok, rd_data_valid, rd_data, busy, oob_err
    );

    modport slave (
        input  clear_req, wr_valid, wr_x, wr_y, wr_data, wr_nopar,
               chk_req, chk_y, rd_valid, rd_x, rd_y, err_clr,
        output wr_ready, chk_done, chk_ok, rd_data_valid, rd_data, busy, oob_err
    );
endinterface

// File: rtl/wireframe_fb_ctrl.sv
// 1-bit-per-pixel framebuffer with per-row parity, clear engine, row parity
// checker and an always-available registered scan-out read port.
module wireframe_fb_ctrl #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int X_W    = 7,
    parameter int Y_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    wireframe_fb_ctrl_if.slave fb
);
    localparam int N      = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(N);
    localparam logic [X_W-1:0]    X_LIM     = X_W'(WIDTH);
    localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, WR_RMW, CLEAR, CHECK, CHECK_END} state_t;

    state_t            state, state_next;
    logic              pix [N];
    logic [HEIGHT-1:0] parity;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [Y_W-1:0]    row_q;
    logic              data_q, nopar_q, old_q;
    logic              chk_bit, chk_acc;
    logic              mem_we, mem_wdata;
    logic [ADDR_W-1:0] mem_waddr;
    logic              wr_in, chk_in, rd_in;
    logic              wr_fire, chk_fire, clr_fire, oob_set;

    function automatic logic [ADDR_W-1:0] lin(input logic [Y_W-1:0] y,
                                               input logic [ADDR_W-1:0] x);
        return ADDR_W'(y) * ADDR_W'(WIDTH) + x;
    endfunction

    assign wr_in  = (fb.wr_x < X_LIM) && (fb.wr_y < Y_LIM);
    assign chk_in = fb.chk_y < Y_LIM;
    assign rd_in  = (fb.rd_x < X_LIM) && (fb.rd_y < Y_LIM);

    assign fb.busy     = (state != IDLE);
    assign fb.wr_ready = (state == IDLE) && !fb.clear_req;

    // IDLE arbitration: clear beats write, write beats check
    assign clr_fire = (state == IDLE) && fb.clear_req;
    assign wr_fire  = fb.wr_valid && fb.wr_ready;
    assign chk_fire = (state == IDLE) && !fb.clear_req && !fb.wr_valid && fb.chk_req;
    assign oob_set  = (wr_fire && !wr_in) || (chk_fire && !chk_in) || (fb.rd_valid && !rd_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = cnt;
        mem_wdata  = 1'b0;
        case (state)
            IDLE: begin
                if (fb.clear_req)                 state_next = CLEAR;
                else if (fb.wr_valid) begin
                    if (wr_in)                    state_next = WR_RMW;
                end
                else if (fb.chk_req && chk_in)    state_next = CHECK;
            end
            WR_RMW: begin
                mem_we     = 1'b1;
                mem_waddr  = wr_addr_q;
                mem_wdata  = data_q;
                state_next = IDLE;
            end
            CLEAR: begin
                mem_we = 1'b1;
                if (cnt == LAST_ADDR) state_next = IDLE;
            end
            CHECK: begin
                if (cnt == LAST_X) state_next = CHECK_END;
            end
            CHECK_END: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) pix[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            wr_addr_q <= '0;
            row_q     <= '0;
            data_q    <= 1'b0;
            nopar_q   <= 1'b0;
            old_q     <= 1'b0;
            chk_bit   <= 1'b0;
            chk_acc   <= 1'b0;
            parity    <= '0;
            fb.chk_done <= 1'b0;
            fb.chk_ok   <= 1'b0;
        end else begin
            fb.chk_done <= 1'b0;
            if (state == IDLE) cnt <= '0;
            else               cnt <= cnt + ADDR_W'(1);

            if (clr_fire) parity <= '0;

            if (wr_fire && wr_in) begin
                wr_addr_q <= lin(fb.wr_y, ADDR_W'(fb.wr_x));
                row_q     <= fb.wr_y;
                data_q    <= fb.wr_data;
                nopar_q   <= fb.wr_nopar;
                old_q     <= pix[lin(fb.wr_y, ADDR_W'(fb.wr_x))];
            end

            if (chk_fire) begin
                if (chk_in) begin
                    row_q   <= fb.chk_y;
                    chk_acc <= 1'b0;
                end else begin
                    fb.chk_done <= 1'b1;
                    fb.chk_ok   <= 1'b0;
                end
            end

            if (state == WR_RMW && !nopar_q)
                parity[row_q] <= parity[row_q] ^ old_q ^ data_q;

            // Read data lags the address by one cycle, so the first CHECK
            // cycle has nothing to fold in and CHECK_END folds the last bit
            if (state == CHECK) begin
                chk_bit <= pix[lin(row_q, cnt)];
                if (cnt != '0) chk_acc <= chk_acc ^ chk_bit;
            end

            if (state == CHECK_END) begin
                fb.chk_done <= 1'b1;
                fb.chk_ok   <= ((chk_acc ^ chk_bit) == parity[row_q]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb.rd_data_valid <= 1'b0;
            fb.rd_data       <= 1'b0;
            fb.oob_err       <= 1'b0;
        end else begin
            fb.rd_data_valid <= fb.rd_valid;
            fb.rd_data       <= (fb.rd_valid && rd_in) ? pix[lin(fb.rd_y, ADDR_W'(fb.rd_x))] : 1'b0;
            if (oob_set)         fb.oob_err <= 1'b1;
            else if (fb.err_clr) fb.oob_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wireframe_fb_ctrl.sv
// Self-checking bench for wireframe_fb_ctrl: table-driven writes/reads/checks,
// a read-data scoreboard queue, and hand-written reset/clear/OOB sequences.
module tb_wireframe_fb_ctrl;
    localparam int WIDTH  = 64;
    localparam int HEIGHT = 48;
    localparam int X_W    = 7;
    localparam int Y_W    = 6;
    localparam int CLEAR_CYCLES = WIDTH * HEIGHT;
    localparam int CHK_LAT      = WIDTH + 2;

    typedef enum {OP_WR, OP_RD, OP_CHK} op_t;
    typedef struct {
        op_t op;
        int  x;
        int  y;
        bit  d;
        bit  nopar;
        bit  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    logic rd_exp_q [$];
    vec_t vecs [$];

    always #5 clk = ~clk;

    wireframe_fb_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) fb ();

    wireframe_fb_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (fb)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic note_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: wait bound expired before the DUT responded", name);
    endtask

    // Read scoreboard: expected pixel pushed at issue, popped on rd_data_valid
    always @(negedge clk) begin
        if (fb.rd_data_valid === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL rd_unexpected: got rd_data_valid=1, required no read outstanding");
            end else begin
                check_output("rd_data", fb.rd_data, rd_exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (fb.busy && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (fb.busy) note_fail("busy_timeout");
    endtask

    task automatic do_write(input int x, input int y, input bit d, input bit nopar);
        bit done;
        int cyc;
        done = 1'b0;
        @(negedge clk);
        fb.wr_valid = 1'b1;
        fb.wr_x = X_W'(x);
        fb.wr_y = Y_W'(y);
        fb.wr_data = d;
        fb.wr_nopar = nopar;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (fb.wr_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done) note_fail("wr_accept_timeout");
        @(negedge clk);
        fb.wr_valid = 1'b0;
        fb.wr_nopar = 1'b0;
        wait_idle(50, cyc);
    endtask

    task automatic do_read(input int x, input int y, input bit exp);
        @(negedge clk);
        fb.rd_valid = 1'b1;
        fb.rd_x = X_W'(x);
        fb.rd_y = Y_W'(y);
        rd_exp_q.push_back(exp);
        @(negedge clk);
        fb.rd_valid = 1'b0;
    endtask

    task automatic do_check(input int y, input bit exp_ok, input int exp_lat);
        int lat;
        int cyc;
        bit seen;
        seen = 1'b0;
        lat = 0;
        @(negedge clk);
        fb.chk_req = 1'b1;
        fb.chk_y = Y_W'(y);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) fb.chk_req = 1'b0;
            if (fb.chk_done) begin
                lat = k;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) note_fail("chk_done_timeout");
        else begin
            check_output($sformatf("chk_latency_y%0d", y), lat, exp_lat);
            check_output($sformatf("chk_ok_y%0d", y), fb.chk_ok, exp_ok);
            @(negedge clk);
            check_output($sformatf("chk_done_pulse_y%0d", y), fb.chk_done, 0);
            check_output($sformatf("chk_ok_hold_y%0d", y), fb.chk_ok, exp_ok);
        end
        wait_idle(50, cyc);
    endtask

    task automatic apply_stimulus(input vec_t v);
        case (v.op)
            OP_WR:  do_write(v.x, v.y, v.d, v.nopar);
            OP_RD:  do_read(v.x, v.y, v.exp);
            OP_CHK: do_check(v.y, v.exp, CHK_LAT);
            default: ;
        endcase
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"}, fb.busy, 1);
        check_output({tag, "_wr_ready"}, fb.wr_ready, 0);
        check_output({tag, "_chk_done"}, fb.chk_done, 0);
        check_output({tag, "_chk_ok"}, fb.chk_ok, 0);
        check_output({tag, "_rd_data_valid"}, fb.rd_data_valid, 0);
        check_output({tag, "_rd_data"}, fb.rd_data, 0);
        check_output({tag, "_oob_err"}, fb.oob_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        logic [5:0] ready_hist;

        fb.clear_req = 1'b0; fb.wr_valid = 1'b0; fb.wr_x = '0; fb.wr_y = '0;
        fb.wr_data = 1'b0; fb.wr_nopar = 1'b0; fb.chk_req = 1'b0; fb.chk_y = '0;
        fb.rd_valid = 1'b0; fb.rd_x = '0; fb.rd_y = '0; fb.err_clr = 1'b0;

        vecs.push_back('{OP_WR, 3, 2, 1, 0, 0});
        vecs.push_back('{OP_WR, 10, 2, 1, 0, 0});
        vecs.push_back('{OP_WR, 3, 2, 0, 0, 0});
        vecs.push_back('{OP_RD, 3, 2, 0, 0, 0});
        vecs.push_back('{OP_RD, 10, 2, 0, 0, 1});
        vecs.push_back('{OP_CHK, 0, 2, 0, 0, 1});
        vecs.push_back('{OP_WR, 4, 9, 1, 1, 0});
        vecs.push_back('{OP_CHK, 0, 9, 0, 0, 0});
        vecs.push_back('{OP_WR, 4, 9, 1, 0, 0});
        vecs.push_back('{OP_CHK, 0, 9, 0, 0, 0});
        vecs.push_back('{OP_WR, 4, 9, 0, 1, 0});
        vecs.push_back('{OP_CHK, 0, 9, 0, 0, 1});
        vecs.push_back('{OP_RD, 4, 9, 0, 0, 0});
        vecs.push_back('{OP_WR, 63, 47, 1, 0, 0});
        vecs.push_back('{OP_RD, 63, 47, 0, 0, 1});
        vecs.push_back('{OP_CHK, 0, 47, 0, 0, 1});
        vecs.push_back('{OP_WR, 0, 0, 1, 0, 0});
        vecs.push_back('{OP_WR, 1, 0, 1, 0, 0});
        vecs.push_back('{OP_CHK, 0, 0, 0, 0, 1});
        vecs.push_back('{OP_RD, 1, 0, 0, 0, 1});

        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Power-up clear must run exactly one pass over the array
        rst_n = 1'b1;
        wait_idle(5000, cyc);
        check_output("initial_clear_cycles", cyc, CLEAR_CYCLES);
        check_output("wr_ready_after_clear", fb.wr_ready, 1);
        do_read(5, 7, 0);
        do_check(7, 1, CHK_LAT);

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        // Held wr_valid with a moving column: only every other cycle accepts
        @(negedge clk);
        ready_hist = '0;
        fb.wr_valid = 1'b1;
        fb.wr_y = Y_W'(3);
        fb.wr_data = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fb.wr_x = X_W'(20 + i);
            #1;
            ready_hist = {ready_hist[4:0], fb.wr_ready};
            @(negedge clk);
        end
        fb.wr_valid = 1'b0;
        check_output("b2b_ready_pattern", ready_hist, 6'b101010);
        wait_idle(50, cyc);
        do_read(21, 3, 0);
        do_read(22, 3, 1);
        do_read(24, 3, 1);
        do_check(3, 1, CHK_LAT);

        // Out-of-range accesses
        do_write(64, 0, 1, 0);
        check_output("oob_wr_err", fb.oob_err, 1);
        check_output("oob_wr_idle", fb.busy, 0);
        @(negedge clk); fb.err_clr = 1'b1;
        @(negedge clk); fb.err_clr = 1'b0;
        check_output("oob_clr", fb.oob_err, 0);
        do_read(0, 1, 0);
        check_output("alias_read_no_err", fb.oob_err, 0);
        do_read(0, 48, 0);
        check_output("oob_rd_err", fb.oob_err, 1);
        @(negedge clk); fb.err_clr = 1'b1;
        @(negedge clk); fb.err_clr = 1'b0;
        do_check(50, 0, 1);
        check_output("oob_chk_err", fb.oob_err, 1);
        do_check(1, 1, CHK_LAT);
        @(negedge clk);
        fb.err_clr = 1'b1; fb.wr_valid = 1'b1; fb.wr_x = X_W'(70); fb.wr_y = '0;
        @(negedge clk);
        fb.err_clr = 1'b0; fb.wr_valid = 1'b0;
        check_output("oob_set_wins", fb.oob_err, 1);
        @(negedge clk); fb.err_clr = 1'b1;
        @(negedge clk); fb.err_clr = 1'b0;
        check_output("oob_clr_alone", fb.oob_err, 0);

        // Read lands on the same edge that WR_RMW writes 1 over 0
        @(negedge clk);
        fb.wr_valid = 1'b1; fb.wr_x = X_W'(3); fb.wr_y = Y_W'(2); fb.wr_data = 1'b1; fb.wr_nopar = 1'b0;
        @(negedge clk);
        fb.wr_valid = 1'b0;
        fb.rd_valid = 1'b1; fb.rd_x = X_W'(3); fb.rd_y = Y_W'(2);
        rd_exp_q.push_back(1'b0);
        @(negedge clk);
        rd_exp_q.push_back(1'b1);
        @(negedge clk);
        fb.rd_valid = 1'b0;
        do_check(2, 1, CHK_LAT);

        // clear_req and wr_valid together: the clear wins
        @(negedge clk);
        fb.clear_req = 1'b1; fb.wr_valid = 1'b1;
        fb.wr_x = X_W'(5); fb.wr_y = Y_W'(5); fb.wr_data = 1'b1;
        #1;
        check_output("clr_blocks_wr_ready", fb.wr_ready, 0);
        @(negedge clk);
        fb.clear_req = 1'b0; fb.wr_valid = 1'b0;
        check_output("clr_busy", fb.busy, 1);
        repeat (5) @(negedge clk);
        do_read(0, 0, 0);
        do_read(63, 47, 1);
        wait_idle(5000, cyc);
        check_output("clr_remaining_cycles", cyc, CLEAR_CYCLES - 9);
        do_read(63, 47, 0);
        do_check(3, 1, CHK_LAT);
        do_check(2, 1, CHK_LAT);

        // Reset in the middle of a check, then in the middle of a clear
        do_read(0, 48, 0);
        check_output("oob_before_reset", fb.oob_err, 1);
        @(negedge clk);
        fb.chk_req = 1'b1; fb.chk_y = Y_W'(2);
        @(negedge clk);
        fb.chk_req = 1'b0;
        repeat (10) @(negedge clk);
        check_output("mid_check_busy", fb.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid_check");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(5000, cyc);
        check_output("rerun_clear_after_check", cyc, CLEAR_CYCLES);
        do_write(8, 8, 1, 0);
        do_write(30, 20, 1, 0);
        @(negedge clk);
        fb.clear_req = 1'b1;
        @(negedge clk);
        fb.clear_req = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid_clear");
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(5000, cyc);
        check_output("rerun_clear_after_clear", cyc, CLEAR_CYCLES);
        do_read(30, 20, 0);
        do_check(20, 1, CHK_LAT);
        do_write(7, 7, 1, 0);
        do_read(7, 7, 1);
        do_check(7, 1, CHK_LAT);

        repeat (3) @(negedge clk);
        check_output("rd_queue_drained", rd_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/wireframe_fb_ctrl.md
Name: wireframe_fb_ctrl

Overview:
- Parametrised 1-bit-per-pixel wireframe framebuffer: pixel storage, per-row parity, and a controller in front of them.
- Adds coordinate (x,y) addressing with bounds protection, read-modify-write parity maintenance, an auto/on-demand clear engine, a row parity check engine and an independent scan-out read port.
- Sits between the line rasteriser (write side) and the display scan-out (read side).

Parameters:
- WIDTH, 64, pixels per row
- HEIGHT, 48, rows
- X_W, 7, width of x coordinate ports (must satisfy 2^X_W > WIDTH)
- Y_W, 6, width of y coordinate ports (must satisfy 2^Y_W > HEIGHT)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear_req  in  1  start full clear (level, sampled in IDLE)
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write accept; transfer when wr_valid&wr_ready
- wr_x  in  X_W  write column
- wr_y  in  Y_W  write row
- wr_data  in  1  pixel value
- wr_nopar  in  1  diagnostic: write pixel without updating row parity
- chk_req  in  1  start row parity check
- chk_y  in  Y_W  row to check
- chk_done  out  1  one-cycle pulse, check result valid
- chk_ok  out  1  1 = stored parity matches row contents; held until next chk_done
- rd_valid  in  1  scan-out read request
- rd_x  in  X_W  read column
- rd_y  in  Y_W  read row
- rd_data_valid  out  1  read data valid
- rd_data  out  1  read pixel
- busy  out  1  controller not in IDLE
- oob_err  out  1  sticky out-of-bounds flag
- err_clr  in  1  clears oob_err

Behaviour:
- Storage: pixel array of WIDTH*HEIGHT bits, linear address y*WIDTH+x; parity register array of HEIGHT bits, parity[y] = XOR of row y.
- Reset: state CLEAR at count 0; parity all 0; busy=1, wr_ready=0, chk_done=0, chk_ok=0, rd_data_valid=0, rd_data=0, oob_err=0. Reset asserted mid-operation aborts it; a clear restarts on release.
- States: IDLE, WR_RMW, CLEAR, CHECK, CHECK_END.
- IDLE priority in one cycle: clear_req > write > chk_req. wr_ready = (state==IDLE) & ~clear_req.
- CLEAR: on entry all parity bits <= 0; writes 0 to one pixel per cycle, address 0..WIDTH*HEIGHT-1; exits to IDLE after the last address. Takes exactly WIDTH*HEIGHT cycles; busy low on the following cycle.
- Write, in-range (x<WIDTH, y<HEIGHT): acceptance cycle latches address/data and reads the old pixel; WR_RMW cycle writes the new pixel and sets parity[y] ^= old^new (skipped if latched wr_nopar); then IDLE. Maximum throughput is one write per 2 cycles.
- Write, out of range: handshake completes, no memory or parity change, oob_err set, stays IDLE.
- Check, in-range: acceptance at cycle T. CHECK reads x=0..WIDTH-1 during T+1..T+WIDTH, XOR-accumulating the 1-cycle-latency data. CHECK_END compares against parity[y]. chk_done pulses at T+WIDTH+2 with chk_ok = match.
- Check, chk_y>=HEIGHT: chk_done pulses at T+1, chk_ok=0, oob_err set, no state change beyond IDLE.
- Read port: independent of the FSM and always available, including during CLEAR/CHECK. rd_data_valid and rd_data are registered one cycle after rd_valid. Same-address write in the same cycle returns the old value. Out-of-range read returns rd_data=0 and sets oob_err.
- oob_err: sticky; err_clr clears it; a simultaneous set wins.
- clear_req, chk_req and wr_valid outside IDLE are ignored (no queueing); chk_req must be held until busy rises.

Test Plan:
- Reset release (WIDTH=64, HEIGHT=48) -> busy=1 for exactly 3072 cycles, then wr_ready=1; reading (5,7) returns 0; check y=7 -> chk_ok=1.
- Write 1 to (3,2), then (10,2), then 0 to (3,2) -> reads return 0,1 at (3,2),(10,2); check y=2 at T gives chk_done at T+66, chk_ok=1. Back-to-back wr_valid is accepted every 2nd cycle.
- Write 1 to (4,9) with wr_nopar=1 -> check y=9 returns chk_ok=0; rewrite 1 to (4,9) with wr_nopar=0 -> chk_ok still 0; write 0 with wr_nopar=1 -> chk_ok=1.
- Write to (64,0), read (0,48), check chk_y=50 -> no memory change, chk_done at T+1 with chk_ok=0, oob_err=1. err_clr with a simultaneous OOB write -> oob_err stays 1; err_clr alone -> 0.
- Read (3,2) in the same cycle its WR_RMW writes 1 over 0 -> rd_data=0; next read -> 1. Reads during CLEAR return valid data one cycle later.
- Assert rst_n=0 mid-CHECK and mid-CLEAR -> outputs at reset values immediately; the full clear reruns; clear_req together with wr_valid in IDLE -> clear wins, write not accepted.
